// File: rtl/pf_insn_queue.sv
// Instruction queue between prefetch and decode: buffers {illegal, pc, insn}
// words, flushes on branch/cache clear, and stops accepting after a bus error.
module pf_insn_queue #(
    parameter int AW         = 30,
    parameter int INSN_WIDTH = 32,
    parameter int LGDEPTH    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_new_pc,
    input  logic                  i_clear_cache,
    input  logic                  i_pf_valid,
    input  logic                  i_pf_illegal,
    input  logic [INSN_WIDTH-1:0] i_pf_insn,
    input  logic [AW-1:0]         i_pf_pc,
    output logic                  o_pf_ready,
    output logic                  o_valid,
    output logic                  o_illegal,
    output logic [INSN_WIDTH-1:0] o_insn,
    output logic [AW-1:0]         o_pc,
    input  logic                  i_ready,
    output logic [LGDEPTH:0]      o_fill
);

    localparam int DEPTH = 1 << LGDEPTH;
    localparam int EW    = 1 + AW + INSN_WIDTH;
    localparam logic [LGDEPTH:0] PTR_ONE = (LGDEPTH+1)'(1);

    logic [LGDEPTH:0] r_rd;
    logic [LGDEPTH:0] r_wr;
    logic             r_halt;
    logic [EW-1:0]    r_mem [DEPTH];

    logic          w_full;
    logic          w_flush;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_full  = (r_wr[LGDEPTH] != r_rd[LGDEPTH]) &&
                     (r_wr[LGDEPTH-1:0] == r_rd[LGDEPTH-1:0]);
    assign w_flush = i_new_pc | i_clear_cache;

    assign o_fill     = r_wr - r_rd;
    assign o_valid    = (o_fill != '0);
    assign o_pf_ready = !w_full && !r_halt;

    assign w_push = i_pf_valid && o_pf_ready && !w_flush;
    assign w_pop  = o_valid && i_ready && !w_flush;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_halt <= 1'b0;
        end else if (w_flush) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_halt <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PTR_ONE;
                if (i_pf_illegal)
                    r_halt <= 1'b1;
            end
            if (w_pop)
                r_rd <= r_rd + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr[LGDEPTH-1:0]] <= {i_pf_illegal, i_pf_pc, i_pf_insn};
    end

    assign w_head    = r_mem[r_rd[LGDEPTH-1:0]];
    assign o_illegal = o_valid && w_head[EW-1];
    assign o_pc      = o_valid ? w_head[EW-2 -: AW] : '0;
    assign o_insn    = o_valid ? w_head[INSN_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_pf_insn_queue.sv
// Directed self-checking bench for pf_insn_queue (LGDEPTH=2, 4 entries).
module tb_pf_insn_queue;

    logic        clk;
    logic        rst_n;
    logic        new_pc;
    logic        clear_cache;
    logic        pf_valid;
    logic        pf_illegal;
    logic [31:0] pf_insn;
    logic [29:0] pf_pc;
    logic        pf_ready;
    logic        valid;
    logic        illegal;
    logic [31:0] insn;
    logic [29:0] pc;
    logic        ready;
    logic [2:0]  fill;

    int tests;
    int fails;

    pf_insn_queue #(.AW(30), .INSN_WIDTH(32), .LGDEPTH(2)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_new_pc(new_pc), .i_clear_cache(clear_cache),
        .i_pf_valid(pf_valid), .i_pf_illegal(pf_illegal), .i_pf_insn(pf_insn),
        .i_pf_pc(pf_pc), .o_pf_ready(pf_ready), .o_valid(valid), .o_illegal(illegal),
        .o_insn(insn), .o_pc(pc), .i_ready(ready), .o_fill(fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] insn_of(input logic [29:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [29:0] a, input logic ill);
        pf_valid   = 1'b1;
        pf_pc      = a;
        pf_insn    = insn_of(a);
        pf_illegal = ill;
    endtask

    task automatic idle();
        pf_valid   = 1'b0;
        pf_illegal = 1'b0;
        ready      = 1'b0;
        new_pc     = 1'b0;
        clear_cache = 1'b0;
    endtask

    task automatic do_flush();
        clear_cache = 1'b1;
        step();
        clear_cache = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (valid !== 1'b0 || fill !== 3'd0 || pf_ready !== 1'b1 ||
            illegal !== 1'b0 || insn !== 32'd0 || pc !== 30'd0) begin
            fails++;
            $display("FAIL reset: valid=%b fill=%0d ready=%b ill=%b insn=%h pc=%h, want 0 0 1 0 0 0",
                     valid, fill, pf_ready, illegal, insn, pc);
        end
    endtask

    task automatic test_order();
        logic [29:0] e;
        for (int k = 0; k < 3; k++) begin
            offer(30'h100 + 30'(4*k), 1'b0);
            step();
        end
        pf_valid = 1'b0;
        tests++;
        if (fill !== 3'd3 || pc !== 30'h100) begin
            fails++;
            $display("FAIL order_fill: fill=%0d pc=%h, want 3 100", fill, pc);
        end
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e = 30'h100 + 30'(4*k);
            tests++;
            if (valid !== 1'b1 || pc !== e || insn !== insn_of(e)) begin
                fails++;
                $display("FAIL order_pop%0d: valid=%b pc=%h insn=%h, want 1 %h %h",
                         k, valid, pc, insn, e, insn_of(e));
            end
            step();
        end
        tests++;
        if (valid !== 1'b0 || pc !== 30'd0 || fill !== 3'd0) begin
            fails++;
            $display("FAIL order_empty: valid=%b pc=%h fill=%0d, want 0 0 0", valid, pc, fill);
        end
        idle();
    endtask

    task automatic test_full_wrap();
        logic [29:0] sb[$];
        logic [29:0] e;
        int sent;
        int got;
        for (int k = 0; k < 4; k++) begin
            offer(30'h300 + 30'(4*k), 1'b0);
            step();
        end
        tests++;
        if (fill !== 3'd4 || pf_ready !== 1'b0) begin
            fails++;
            $display("FAIL full: fill=%0d pf_ready=%b, want 4 0", fill, pf_ready);
        end
        // full with a pop and an offered word: the word must not enter
        offer(30'h310, 1'b0);
        ready = 1'b1;
        step();
        idle();
        tests++;
        if (fill !== 3'd3 || pf_ready !== 1'b1 || pc !== 30'h304) begin
            fails++;
            $display("FAIL full_pop: fill=%0d pf_ready=%b pc=%h, want 3 1 304", fill, pf_ready, pc);
        end
        do_flush();
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
            pf_valid   = (sent < 20);
            pf_illegal = 1'b0;
            pf_pc      = 30'h400 + 30'(4*sent);
            pf_insn    = insn_of(pf_pc);
            ready      = 1'($urandom_range(0, 1));
            if (pf_valid && pf_ready) begin
                sb.push_back(pf_pc);
                sent++;
            end
            if (valid && ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: pc=%h with nothing outstanding", pc);
                end else begin
                    e = sb.pop_front();
                    got++;
                    if (pc !== e || insn !== insn_of(e)) begin
                        fails++;
                        $display("FAIL stream_word: pc=%h insn=%h, want %h %h", pc, insn, e, insn_of(e));
                    end
                end
            end
            step();
        end
        idle();
        tests++;
        if (got != 20 || sent != 20 || valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_count: got=%0d sent=%0d valid=%b, want 20 20 0", got, sent, valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [29:0] e;
        offer(30'h500, 1'b0);
        step();
        tests++;
        if (valid !== 1'b1 || pc !== 30'h500) begin
            fails++;
            $display("FAIL latency: valid=%b pc=%h, want 1 500", valid, pc);
        end
        offer(30'h504, 1'b0);
        step();
        ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            offer(30'h504 + 30'(4*k), 1'b0);
            step();
            e = 30'h500 + 30'(4*k);
            tests++;
            if (fill !== 3'd2 || pc !== e) begin
                fails++;
                $display("FAIL steady%0d: fill=%0d pc=%h, want 2 %h", k, fill, pc, e);
            end
        end
        idle();
        do_flush();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            offer(30'h600 + 30'(4*k), 1'b0);
            step();
        end
        offer(30'h60C, 1'b0);
        ready  = 1'b1;
        new_pc = 1'b1;
        step();
        idle();
        tests++;
        if (fill !== 3'd0 || valid !== 1'b0 || insn !== 32'd0 || pf_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush: fill=%0d valid=%b insn=%h pf_ready=%b, want 0 0 0 1",
                     fill, valid, insn, pf_ready);
        end
        offer(30'h700, 1'b0);
        step();
        idle();
        tests++;
        if (fill !== 3'd1 || pc !== 30'h700) begin
            fails++;
            $display("FAIL flush_after: fill=%0d pc=%h, want 1 700", fill, pc);
        end
        do_flush();
    endtask

    task automatic test_halt();
        offer(30'h200, 1'b0);
        pf_insn = 32'hA;
        step();
        offer(30'h204, 1'b1);
        step();
        offer(30'h208, 1'b0);
        tests++;
        if (pf_ready !== 1'b0) begin
            fails++;
            $display("FAIL halt_ready: pf_ready=%b, want 0", pf_ready);
        end
        step();
        pf_valid = 1'b0;
        tests++;
        if (fill !== 3'd2 || pc !== 30'h200 || insn !== 32'hA || illegal !== 1'b0) begin
            fails++;
            $display("FAIL halt_head: fill=%0d pc=%h insn=%h ill=%b, want 2 200 a 0", fill, pc, insn, illegal);
        end
        ready = 1'b1;
        step();
        tests++;
        if (valid !== 1'b1 || pc !== 30'h204 || illegal !== 1'b1) begin
            fails++;
            $display("FAIL halt_err: valid=%b pc=%h ill=%b, want 1 204 1", valid, pc, illegal);
        end
        step();
        tests++;
        if (valid !== 1'b0 || illegal !== 1'b0 || pf_ready !== 1'b0) begin
            fails++;
            $display("FAIL halt_drain: valid=%b ill=%b pf_ready=%b, want 0 0 0", valid, illegal, pf_ready);
        end
        idle();
        do_flush();
        tests++;
        if (pf_ready !== 1'b1) begin
            fails++;
            $display("FAIL halt_clear: pf_ready=%b, want 1", pf_ready);
        end
    endtask

    task automatic test_async_reset();
        offer(30'h800, 1'b1);
        step();
        idle();
        tests++;
        if (illegal !== 1'b1 || fill !== 3'd1 || pf_ready !== 1'b0) begin
            fails++;
            $display("FAIL areset_pre: ill=%b fill=%0d pf_ready=%b, want 1 1 0", illegal, fill, pf_ready);
        end
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if (valid !== 1'b0 || fill !== 3'd0 || illegal !== 1'b0 || pf_ready !== 1'b1) begin
            fails++;
            $display("FAIL areset: valid=%b fill=%0d ill=%b pf_ready=%b, want 0 0 0 1",
                     valid, fill, illegal, pf_ready);
        end
        #2 rst_n = 1'b1;
        offer(30'h900, 1'b0);
        step();
        idle();
        tests++;
        if (valid !== 1'b1 || pc !== 30'h900 || fill !== 3'd1) begin
            fails++;
            $display("FAIL areset_push: valid=%b pc=%h fill=%0d, want 1 900 1", valid, pc, fill);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        pf_pc = '0;
        pf_insn = '0;
        idle();
        #12;
        test_reset();
        rst_n = 1'b1;
        step();
        test_order();
        test_full_wrap();
        test_back_to_back();
        test_flush();
        test_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
